// File: rtl/aes_selftest_ctrl.sv
// AES power-on self-test sequencer.
// For each selected key size it runs NUM_VEC encrypt/decrypt round trips
// through an external AES core and reports pass/fail per key size.
// Optional build macro SELFTEST_KAT_EN additionally checks the vector-0
// ciphertext against the FIPS-197 known answers.
module aes_selftest_ctrl #(
  parameter int NUM_VEC     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  output logic         core_start,
  output logic         core_dir,
  output logic [1:0]   core_keylen,
  output logic [255:0] core_key,
  output logic [127:0] core_in,
  input  logic         core_done,
  input  logic [127:0] core_out,
  output logic         busy,
  output logic         done,
  output logic [2:0]   pass,
  output logic [2:0]   fail
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [255:0] SELFTEST_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_BASE = 128'h00112233445566778899aabbccddeeff;

  typedef enum logic [2:0] {
    IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, NEXT, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       mode_q, mode_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       pass_q, pass_d;
  logic [2:0]       fail_q, fail_d;
  logic [127:0]     ct_q, ct_d;
  logic [127:0]     dec_q, dec_d;

  // Plaintext of vector k: base pattern with every byte XORed by k.
  function automatic logic [127:0] pt_of(input logic [7:0] k);
    return PT_BASE ^ {16{k}};
  endfunction

`ifdef SELFTEST_KAT_EN
  // FIPS-197 appendix C ciphertexts for the base plaintext and key.
  function automatic logic [127:0] kat_ct(input logic [1:0] sz);
    case (sz)
      2'b00:   return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'b01:   return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction
`endif

  // Control state register; reset forces an idle, all-clear controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      size_q  <= '0;
      mode_q  <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      mode_q  <= mode_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Captured core results; data only, so no reset.
  always_ff @(posedge clk) begin
    ct_q  <= ct_d;
    dec_q <= dec_d;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    size_d  = size_q;
    mode_d  = mode_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ct_d    = ct_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ENC_REQ;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = '0;
          fail_d  = '0;
          idx_d   = '0;
          mode_d  = mode;
          size_d  = (mode == 2'b11) ? 2'b00 : mode;
        end
      end
      ENC_REQ: begin
        tmo_d   = '0;
        state_d = ENC_WAIT;
      end
      ENC_WAIT: begin
        if (core_done) begin
          ct_d    = core_out;
          state_d = DEC_REQ;
`ifdef SELFTEST_KAT_EN
          if (idx_q == 8'd0 && core_out != kat_ct(size_q)) fail_d[size_q] = 1'b1;
`endif
        end else if (tmo_q == TMO_LAST) begin
          fail_d[size_q] = 1'b1;
          state_d        = NEXT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DEC_REQ: begin
        tmo_d   = '0;
        state_d = DEC_WAIT;
      end
      DEC_WAIT: begin
        if (core_done) begin
          dec_d   = core_out;
          state_d = CHECK;
        end else if (tmo_q == TMO_LAST) begin
          fail_d[size_q] = 1'b1;
          state_d        = NEXT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      CHECK: begin
        if (dec_q != pt_of(idx_q)) fail_d[size_q] = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if ((int'(idx_q) < NUM_VEC - 1) && !fail_q[size_q]) begin
          idx_d   = idx_q + 8'd1;
          state_d = ENC_REQ;
        end else begin
          // A failed size stops early; report it and move on.
          pass_d[size_q] = ~fail_q[size_q];
          idx_d          = '0;
          if (mode_q == 2'b11 && size_q != 2'b10) begin
            size_d  = size_q + 2'd1;
            state_d = ENC_REQ;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Core request signals decoded from state; operands stay stable REQ..WAIT.
  always_comb begin
    core_start  = (state_q == ENC_REQ) || (state_q == DEC_REQ);
    core_dir    = (state_q == DEC_REQ) || (state_q == DEC_WAIT);
    core_keylen = (state_q == IDLE) ? 2'b00 : size_q;
    case (state_q)
      ENC_REQ, ENC_WAIT: core_in = pt_of(idx_q);
      DEC_REQ, DEC_WAIT: core_in = ct_q;
      default:           core_in = '0;
    endcase
  end

  assign core_key = SELFTEST_KEY;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Directed bench for aes_selftest_ctrl with a behavioural stand-in AES core.
// The stand-in core XORs with a per-keylen mask chosen so that vector 0
// encrypts to the FIPS-197 answer; decrypt undoes the same mask.
module tb_aes_selftest_ctrl;

  localparam int NUM_VEC     = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2 = P0 ^ {16{8'h02}};

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   mode;
  logic         core_start, core_dir;
  logic [1:0]   core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_in;
  logic         core_done = 1'b0;
  logic [127:0] core_out  = '0;
  logic         busy, done;
  logic [2:0]   pass, fail;

  // Stand-in core behaviour controls.
  int   lat    = 1;
  bit   hang   = 1'b0;
  bit   flip   = 1'b0;
  bit   ct_bad = 1'b0;
  int   nstarts = 0;
  int   cnt     = 0;
  logic [1:0] kl_q[$];
  logic [127:0] core_r;

  int n_tests = 0;
  int n_fail  = 0;

  aes_selftest_ctrl #(.NUM_VEC(NUM_VEC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .core_start(core_start), .core_dir(core_dir), .core_keylen(core_keylen),
    .core_key(core_key), .core_in(core_in), .core_done(core_done),
    .core_out(core_out), .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] kat(input logic [1:0] kl);
    case (kl)
      2'b00:   return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'b01:   return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  // Stand-in AES core: result after lat cycles, optional faults.
  always @(posedge clk) begin
    if (core_start) begin
      nstarts <= nstarts + 1;
      if (!core_dir) kl_q.push_back(core_keylen);
      core_r = core_in ^ P0 ^ kat(core_keylen);
      if (ct_bad && core_keylen == 2'b00) core_r = core_r ^ 128'h1;
      if (flip && core_dir && core_r == PT2) core_r[0] = ~core_r[0];
      core_out <= core_r;
      if (hang) begin
        cnt       <= 0;
        core_done <= 1'b0;
      end else begin
        cnt       <= lat - 1;
        core_done <= (lat == 1);
      end
    end else if (cnt > 0) begin
      cnt       <= cnt - 1;
      core_done <= (cnt == 1);
    end else begin
      core_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (cycle 1).
  // Optionally pulses start with another mode mid-run.
  task automatic wait_done(input bit inject, output int cyc, output bit busy_hi);
    cyc     = 1;
    busy_hi = 1'b1;
    while (!done && cyc < 2000) begin
      if (!busy) busy_hi = 1'b0;
      if (inject && cyc == 5) begin
        start = 1'b1;
        mode  = 2'b11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 256'(done), 256'd1);
  endtask

  function automatic logic [255:0] out_vec();
    return 256'({core_start, core_dir, core_keylen, busy, done, pass, fail, core_in});
  endfunction

  initial begin
    int  cyc;
    bit  bh;
    int  s0;
    int  b;
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 256'd0);
    reset = 1'b0;

    // mode 00, zero-wait core, stray start mid-run must be ignored
    s0 = nstarts;
    launch(2'b00);
    wait_done(1'b1, cyc, bh);
    check("m00_latency", 256'(cyc), 256'd25);
    check("m00_starts", 256'(nstarts - s0), 256'd8);
    check("m00_passfail", 256'({pass, fail}), 256'({3'b001, 3'b000}));
    check("m00_busy_run", 256'(bh), 256'd1);
    check("m00_busy_fin", 256'(busy), 256'd0);
    repeat (3) @(negedge clk);
    check("m00_hold", 256'({done, pass, fail}), 256'({1'b1, 3'b001, 3'b000}));

    // mode 11, all three sizes in order
    b = kl_q.size();
    launch(2'b11);
    wait_done(1'b0, cyc, bh);
    check("m11_latency", 256'(cyc), 256'd73);
    check("m11_passfail", 256'({pass, fail}), 256'({3'b111, 3'b000}));
    check("m11_busy_run", 256'(bh), 256'd1);
    check("m11_enc_count", 256'(kl_q.size() - b), 256'd12);
    check("m11_keylen_seq", 256'({kl_q[b], kl_q[b+4], kl_q[b+8], kl_q[b+11]}),
          256'({2'b00, 2'b01, 2'b10, 2'b10}));

    // mode 01, decrypt of vector 2 corrupted
    flip = 1'b1;
    s0   = nstarts;
    launch(2'b01);
    wait_done(1'b0, cyc, bh);
    check("m01_flip_passfail", 256'({pass, fail}), 256'({3'b000, 3'b010}));
    check("m01_flip_starts", 256'(nstarts - s0), 256'd6);
    flip = 1'b0;

    // mode 10, core never answers
    hang = 1'b1;
    s0   = nstarts;
    launch(2'b10);
    wait_done(1'b0, cyc, bh);
    check("m10_hang_latency", 256'(cyc), 256'd11);
    check("m10_hang_state", 256'({done, pass, fail}), 256'({1'b1, 3'b000, 3'b100}));
    check("m10_hang_starts", 256'(nstarts - s0), 256'd1);
    hang = 1'b0;

    // reset during DEC_WAIT with a slow core, rerun while stale done arrives
    lat = 3;
    launch(2'b11);
    cyc = 0;
    while (!(core_start && core_dir) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_dec", 256'(core_start && core_dir), 256'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", out_vec(), 256'd0);
    reset = 1'b0;
    mode  = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_stale_done_seen", 256'({core_done, core_start}), 256'({1'b1, 1'b1}));
    wait_done(1'b0, cyc, bh);
    check("rerun_latency", 256'(cyc), 256'd121);
    check("rerun_passfail", 256'({pass, fail}), 256'({3'b111, 3'b000}));
    lat = 1;

    // wrong ciphertext, correct round trip, 128-bit key
    ct_bad = 1'b1;
    launch(2'b00);
    wait_done(1'b0, cyc, bh);
`ifdef SELFTEST_KAT_EN
    check("kat_passfail", 256'({pass, fail}), 256'({3'b000, 3'b001}));
`else
    check("kat_passfail", 256'({pass, fail}), 256'({3'b001, 3'b000}));
`endif
    ct_bad = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_selftest_ctrl.md
AES_SELFTEST_CTRL -- requirements
Module: aes_selftest_ctrl

Interface
REQ-001 SHALL have parameter NUM_VEC, default 4, meaning vectors per key size (1..256).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning max cycles waiting for core_done (>=2).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port mode  input  2  00=128, 01=192, 10=256, 11=all three in order 128,192,256; latched at accepted start.
REQ-007 SHALL have port core_start  output  1  one-cycle operation request to AES core.
REQ-008 SHALL have port core_dir  output  1  0=encrypt, 1=decrypt.
REQ-009 SHALL have port core_keylen  output  2  00/01/10 = 128/192/256.
REQ-010 SHALL have port core_key  output  256  constant 256'h000102...1e1f, core uses MSB-aligned bits per keylen.
REQ-011 SHALL have port core_in  output  128  data block to core.
REQ-012 SHALL have ports core_done  input  1  and core_out  input  128  result valid while core_done=1.
REQ-013 SHALL have ports busy, done  output  1 each, and pass, fail  output  3 each (bit0=128, bit1=192, bit2=256).

Function
REQ-014 SHALL use FSM states IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, NEXT, FIN.
REQ-015 IDLE: start=1 -> ENC_REQ next cycle, busy=1, done=0, pass/fail for all three bits cleared, vector index=0, size = first size of mode.
REQ-016 Plaintext of vector k SHALL be 128'h00112233445566778899aabbccddeeff XOR {16{k[7:0]}}.
REQ-017 ENC_REQ: core_start=1, core_dir=0, core_in=plaintext, exactly one cycle -> ENC_WAIT.
REQ-018 ENC_WAIT: on core_done capture core_out as ciphertext -> DEC_REQ; core_in and core_dir SHALL stay stable from REQ until done.
REQ-019 DEC_REQ: core_start=1, core_dir=1, core_in=captured ciphertext, one cycle -> DEC_WAIT; DEC_WAIT captures core_out -> CHECK.
REQ-020 Timeout counter SHALL reset on entry to each WAIT state; TIMEOUT_CYC cycles without core_done -> set fail[size], abandon remaining vectors of that size -> NEXT.
REQ-021 CHECK: decrypted != plaintext -> set fail[size]; -> NEXT (one cycle).
REQ-022 NEXT: index < NUM_VEC-1 and fail[size]=0 -> index+1, ENC_REQ; else pass[size]=~fail[size], index=0, advance to next size (mode 11) or FIN.
REQ-023 FIN: busy=0, done=1 -> IDLE; done and pass/fail SHALL hold until next accepted start or reset.
REQ-024 start while busy SHALL be ignored; core_done outside WAIT states SHALL be ignored.
REQ-025 Per-vector latency with zero-wait core (core_done in cycle after core_start) SHALL be 6 cycles (ENC_REQ..NEXT).
REQ-026 pass[i] and fail[i] SHALL never both be 1; sizes not selected by mode SHALL read 0/0.

Reset
REQ-027 reset=1 at any clock, including mid-run, SHALL force IDLE, index=0, timeout=0, core_start=0, core_dir=0, core_keylen=0, core_in=0, busy=0, done=0, pass=0, fail=0.
REQ-028 reset SHALL take priority over start and core_done in the same cycle.

Configuration
REQ-029 Macro SELFTEST_KAT_EN defined: in ENC_WAIT of vector 0, captured ciphertext SHALL also be compared to FIPS-197 answers 69c4e0d86a7b0430d8cdb78070b4c55a (128), dda97ca4864cdfe06eaf70a0ec0d7191 (192), 8ea2b7ca516745bfeafc49904b496089 (256); mismatch sets fail[size], sequence otherwise continues unchanged.
REQ-030 SELFTEST_KAT_EN undefined: only round-trip check of REQ-021 applies; no KAT constants synthesised.

Verification
REQ-031 mode=00, correct zero-wait core, NUM_VEC=4, start pulse -> 8 core_start pulses, done after 24+overhead cycles, pass=001, fail=000.
REQ-032 mode=11, correct core -> keylen sequence 00,01,10, pass=111, fail=000, busy high throughout.
REQ-033 mode=01, core flips bit 0 of decrypt output on vector 2 -> fail=010, pass=000, no vector 3 issued.
REQ-034 mode=10, core never asserts core_done -> fail=100 after TIMEOUT_CYC cycles in ENC_WAIT, done=1.
REQ-035 reset asserted in DEC_WAIT of mode=11 run, start re-issued while core still returning done -> all outputs 0 at reset, stale done ignored, clean rerun passes.
REQ-036 SELFTEST_KAT_EN defined, core returns correct round trip but wrong ciphertext for 128 -> fail=001; undefined -> pass=001.
